// File: rtl/pipe_test_pkg.sv
// Shared types for the pipe test sequencer: FSM states, run status codes
// and the generator pattern-mode constants.
package pipe_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_RUN   = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        STAT_NONE    = 2'd0,
        STAT_OK      = 2'd1,
        STAT_ABORT   = 2'd2,
        STAT_TIMEOUT = 2'd3
    } status_e;

    localparam logic MODE_COUNT = 1'b0;
    localparam logic MODE_LFSR  = 1'b1;

endpackage

// File: rtl/pipe_test_sequencer_if.sv
// Command, generator-control and status signals of the pipe test sequencer.
// slave = sequencer side, master = the controller/generator side.
interface pipe_test_sequencer_if #(
    parameter int CNT_W = 32
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic [31:0]      cmd_throttle;
    logic [CNT_W-1:0] cmd_words;
    logic             abort;

    logic             gen_reset;
    logic             gen_start;
    logic             gen_mode;
    logic             gen_throttle_set;
    logic [31:0]      gen_throttle_val;
    logic             gen_write;
    logic             pipe_write;

    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [CNT_W-1:0] words_sent;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_throttle, cmd_words, abort, gen_write,
        output cmd_ready, gen_reset, gen_start, gen_mode, gen_throttle_set,
               gen_throttle_val, pipe_write, busy, done, status, words_sent
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_throttle, cmd_words, abort, gen_write,
        input  cmd_ready, gen_reset, gen_start, gen_mode, gen_throttle_set,
               gen_throttle_val, pipe_write, busy, done, status, words_sent
    );

endinterface

// File: rtl/pipe_seq_watchdog.sv
// Stall watchdog for the RUN phase. Only compiled when PIPE_SEQ_WATCHDOG_EN
// is defined; the default build carries no watchdog logic at all.
// expired is raised in the idle cycle that brings the count to 2^TMO_W-1,
// so the sequencer leaves RUN on the same edge the counter reaches its top.
`ifdef PIPE_SEQ_WATCHDOG_EN
module pipe_seq_watchdog #(
    parameter int TMO_W = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMO_W-1:0] CNT_MAX = '1;
    localparam logic [TMO_W-1:0] CNT_PRE = CNT_MAX - TMO_W'(1);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    // stall count: restart on progress or outside RUN, else count up
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && !clear && (cnt_q == CNT_PRE);

endmodule
`endif

// File: rtl/pipe_test_sequencer.sv
// Pipe test sequencer: accepts a run command, resets and configures the
// pattern generator, gates its write strobe into the pipe FIFO and reports
// progress and the run outcome.
// Optional feature: define PIPE_SEQ_WATCHDOG_EN to add a RUN stall watchdog.
//
// state | meaning
// IDLE  | waiting for a command, generator held in reset
// RST   | generator reset held for RST_CYCLES cycles
// LOAD  | throttle value pushed to the generator
// START | one-cycle generator start pulse
// RUN   | counting gated writes until the requested word count
// FIN   | one-cycle done pulse, status valid
module pipe_test_sequencer
    import pipe_test_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4,
    parameter int TMO_W      = 20
) (
    input logic                   clk,
    input logic                   reset,
    pipe_test_sequencer_if.slave  bus
);

    localparam int               RC_W    = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RST_CYCLES - 1);

    state_e           state_q, state_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic             mode_q, mode_d;
    logic [31:0]      thr_q, thr_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    status_e          status_q, status_d;

    logic accept;
    logic last_word;
    logic timeout;

    assign accept    = (state_q == ST_IDLE) && bus.cmd_valid && !bus.abort;
    assign last_word = bus.gen_write && (sent_q == words_q - CNT_W'(1));

`ifdef PIPE_SEQ_WATCHDOG_EN
    pipe_seq_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.gen_write),
        .enable  (state_q == ST_RUN),
        .expired (timeout)
    );
`else
    // no watchdog: TMO_W has no effect and this is constant false
    assign timeout = (TMO_W < 0);
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state; abort wins over completion and timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_RST;
            ST_RST: begin
                if (bus.abort)        state_d = ST_FIN;
                else if (rc_q == '0)  state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.abort || words_q == '0) state_d = ST_FIN;
                else                            state_d = ST_START;
            end
            ST_START: state_d = ST_FIN == ST_FIN && bus.abort ? ST_FIN : ST_RUN;
            ST_RUN:   if (bus.abort || last_word || timeout) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // command latch, reset timer, progress count and outcome
    always_comb begin
        rc_d     = rc_q;
        mode_d   = mode_q;
        thr_d    = thr_q;
        words_d  = words_q;
        sent_d   = sent_q;
        status_d = status_q;
        if (accept) begin
            rc_d     = RC_LOAD;
            mode_d   = bus.cmd_mode;
            thr_d    = bus.cmd_throttle;
            words_d  = bus.cmd_words;
            sent_d   = '0;
            status_d = STAT_NONE;
        end
        if (state_q == ST_RST && rc_q != '0) begin
            rc_d = rc_q - RC_W'(1);
        end
        if (state_q == ST_RUN && bus.gen_write && !bus.abort) begin
            sent_d = sent_q + CNT_W'(1);
        end
        if (state_d == ST_FIN && state_q != ST_FIN) begin
            if (bus.abort)                                       status_d = STAT_ABORT;
            else if (state_q == ST_RUN && !last_word && timeout) status_d = STAT_TIMEOUT;
            else                                                 status_d = STAT_OK;
        end
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rc_q     <= '0;
            mode_q   <= MODE_COUNT;
            thr_q    <= '0;
            words_q  <= '0;
            sent_q   <= '0;
            status_q <= STAT_NONE;
        end else begin
            rc_q     <= rc_d;
            mode_q   <= mode_d;
            thr_q    <= thr_d;
            words_q  <= words_d;
            sent_q   <= sent_d;
            status_q <= status_d;
        end
    end

    // state-decoded outputs
    always_comb begin
        bus.cmd_ready        = (state_q == ST_IDLE);
        bus.gen_reset        = (state_q == ST_IDLE) || (state_q == ST_RST);
        bus.gen_throttle_set = (state_q == ST_LOAD);
        bus.gen_start        = (state_q == ST_START);
        bus.pipe_write       = bus.gen_write && (state_q == ST_RUN);
        bus.busy             = (state_q != ST_IDLE);
        bus.done             = (state_q == ST_FIN);
    end

    assign bus.gen_mode         = (mode_q == MODE_LFSR);
    assign bus.gen_throttle_val = thr_q;
    assign bus.status           = status_q;
    assign bus.words_sent       = sent_q;

endmodule
